nonce_result_scanner: RTL and testbench

//  Downstream stage of the nonce-sweep hasher. After the hasher writes NUM_NONCES h0 words to

---
 rtl/nonce_result_scanner_pkg.sv | 19 +
 rtl/nonce_result_scanner_if.sv | 40 ++++
 rtl/nonce_result_scanner_hash_min_tracker.sv | 65 ++++++
 rtl/nonce_result_scanner.sv | 144 ++++++++++++++
 tb/tb_nonce_result_scanner.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nonce_result_scanner_pkg.sv
`default_nettype none
// ============================================================================
// Module : nonce_result_scanner_pkg
// Brief  : Shared types and constants for the nonce result scanner.
// Rev    : 1.0 - initial release
// ============================================================================
package nonce_result_scanner_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } scan_state_t;

    localparam int          SUMMARY_WORDS = 3;
    localparam logic [31:0] HASH_MAX      = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/nonce_result_scanner_if.sv
`default_nettype none
// ============================================================================
// Module : nonce_result_scanner_if
// Brief  : Start/done control, scan results and single-port memory bus.
// Rev    : 1.0 - initial release
// ============================================================================
interface nonce_result_scanner_if #(
    parameter int NUM_NONCES = 16
);
    localparam int CNT_W = $clog2(NUM_NONCES + 1);

    logic             start;
    logic [15:0]      result_addr;
    logic [15:0]      summary_addr;
    logic [31:0]      target;
    logic             done;
    logic             found;
    logic [31:0]      best_nonce;
    logic [31:0]      best_hash;
    logic [CNT_W-1:0] hit_count;
    logic             mem_clk;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;

    modport slave (
        input  start, result_addr, summary_addr, target, mem_read_data,
        output done, found, best_nonce, best_hash, hit_count,
               mem_clk, mem_we, mem_addr, mem_write_data
    );

    modport master (
        output start, result_addr, summary_addr, target, mem_read_data,
        input  done, found, best_nonce, best_hash, hit_count,
               mem_clk, mem_we, mem_addr, mem_write_data
    );

endinterface
`default_nettype wire

// File: rtl/nonce_result_scanner_hash_min_tracker.sv
`default_nettype none
// ============================================================================
// Module : nonce_result_scanner_hash_min_tracker
// Brief  : Running minimum hash with its index, plus count of hashes <= target.
// Rev    : 1.0 - initial release
// ============================================================================
module nonce_result_scanner_hash_min_tracker
    import nonce_result_scanner_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic [31:0]      hash_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      target_i,
    output logic [31:0]      best_hash_o,
    output logic [IDX_W-1:0] best_idx_o,
    output logic [IDX_W-1:0] hit_count_o
);

    logic [31:0]      best_hash_q, best_hash_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [IDX_W-1:0] hit_count_q, hit_count_d;

    always_comb begin
        best_hash_d = best_hash_q;
        best_idx_d  = best_idx_q;
        hit_count_d = hit_count_q;
        if (clr_i) begin
            best_hash_d = HASH_MAX;
            best_idx_d  = '0;
            hit_count_d = '0;
        end else if (valid_i) begin
            // Strict compare keeps the lowest index on ties.
            if (hash_i < best_hash_q) begin
                best_hash_d = hash_i;
                best_idx_d  = idx_i;
            end
            if (hash_i <= target_i) begin
                hit_count_d = hit_count_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            best_hash_q <= HASH_MAX;
            best_idx_q  <= '0;
            hit_count_q <= '0;
        end else begin
            best_hash_q <= best_hash_d;
            best_idx_q  <= best_idx_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign best_hash_o = best_hash_q;
    assign best_idx_o  = best_idx_q;
    assign hit_count_o = hit_count_q;

endmodule
`default_nettype wire

// File: rtl/nonce_result_scanner.sv
`default_nettype none
// ============================================================================
// Module : nonce_result_scanner
// Brief  : Streams hasher results from memory, finds the best nonce, writes a summary.
// Rev    : 1.0 - initial release
// ============================================================================
module nonce_result_scanner
    import nonce_result_scanner_pkg::*;
#(
    parameter int NUM_NONCES = 16,
    parameter int CNT_W      = $clog2(NUM_NONCES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    nonce_result_scanner_if.slave bus
);

    // Sequence counter must also reach the last summary word index.
    localparam int SEQ_W = (CNT_W > 2) ? CNT_W : 2;

    scan_state_t      state_q, state_d;
    logic [SEQ_W-1:0] cnt_q, cnt_d;
    logic [15:0]      result_addr_q, result_addr_d;
    logic [15:0]      summary_addr_q, summary_addr_d;
    logic [31:0]      target_q, target_d;

    logic             start_accept;
    logic             trk_valid;
    logic [CNT_W-1:0] trk_idx;
    logic [31:0]      best_hash;
    logic [CNT_W-1:0] best_idx;
    logic [CNT_W-1:0] hit_count;

    assign start_accept = (state_q == S_IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            result_addr_q  <= '0;
            summary_addr_q <= '0;
            target_q       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            result_addr_q  <= result_addr_d;
            summary_addr_q <= summary_addr_d;
            target_q       <= target_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        result_addr_d  = result_addr_q;
        summary_addr_d = summary_addr_q;
        target_d       = target_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d        = S_READ;
                    cnt_d          = '0;
                    result_addr_d  = bus.result_addr;
                    summary_addr_d = bus.summary_addr;
                    target_d       = bus.target;
                end
            end
            S_READ: begin
                // One extra cycle drains the last read's one-cycle latency.
                if (cnt_q == SEQ_W'(NUM_NONCES)) begin
                    state_d = S_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SEQ_W'(1);
                end
            end
            S_WRITE: begin
                if (cnt_q == SEQ_W'(SUMMARY_WORDS - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SEQ_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.done           = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
        case (state_q)
            S_IDLE: begin
                bus.done = 1'b1;
            end
            S_READ: begin
                bus.mem_addr = result_addr_q + 16'(cnt_q);
            end
            S_WRITE: begin
                bus.mem_we   = 1'b1;
                bus.mem_addr = summary_addr_q + 16'(cnt_q);
                case (cnt_q)
                    SEQ_W'(0): bus.mem_write_data = 32'(best_idx);
                    SEQ_W'(1): bus.mem_write_data = best_hash;
                    default:   bus.mem_write_data = 32'(hit_count);
                endcase
            end
            default: begin
                bus.done = 1'b0;
            end
        endcase
    end

    assign trk_valid = (state_q == S_READ) && (cnt_q != '0);
    assign trk_idx   = CNT_W'(cnt_q - SEQ_W'(1));

    nonce_result_scanner_hash_min_tracker #(
        .IDX_W(CNT_W)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (start_accept),
        .valid_i    (trk_valid),
        .hash_i     (bus.mem_read_data),
        .idx_i      (trk_idx),
        .target_i   (target_q),
        .best_hash_o(best_hash),
        .best_idx_o (best_idx),
        .hit_count_o(hit_count)
    );

    assign bus.found      = (hit_count != '0);
    assign bus.best_nonce = 32'(best_idx);
    assign bus.best_hash  = best_hash;
    assign bus.hit_count  = hit_count;
    assign bus.mem_clk    = clk;

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_scanner.sv
`default_nettype none
// ============================================================================
// Module : tb_nonce_result_scanner
// Brief  : Directed scoreboard bench with a behavioural single-port memory.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_nonce_result_scanner;

    localparam int NUM   = 16;
    localparam int CNT_W = $clog2(NUM + 1);

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic             found;
        logic [31:0]      nonce;
        logic [31:0]      hash;
        logic [CNT_W-1:0] hits;
        int               lat;
    } res_t;

    typedef struct {
        logic             done;
        logic             we;
        logic [15:0]      addr;
        logic [31:0]      wd;
        logic             found;
        logic [31:0]      nonce;
        logic [31:0]      hash;
        logic [CNT_W-1:0] hits;
    } snap_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_we = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] rd_q;
    logic        mon_en = 1'b0;
    logic        fin_req = 1'b0;

    logic [31:0] mem [0:65535];

    wr_t   wq[$];
    res_t  rq[$];
    snap_t sq[$];

    int errors = 0;
    int checks = 0;

    nonce_result_scanner_if #(.NUM_NONCES(NUM)) bus ();

    nonce_result_scanner #(.NUM_NONCES(NUM)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge bus.mem_clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_write_data;
        else if (ld_we) mem[ld_addr] <= ld_data;
        rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_read_data = rd_q;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents writes, completion or a snapshot point.
    logic prev_done = 1'b1;
    int   lowcnt = 0;
    wr_t   w_e;
    res_t  r_e;
    snap_t s_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_we) begin
                if (wq.size() == 0) chk("unexpected_write", 32'(bus.mem_addr), 32'hDEAD);
                else begin
                    w_e = wq.pop_front();
                    chk("wr_addr", 32'(bus.mem_addr), 32'(w_e.addr));
                    chk("wr_data", bus.mem_write_data, w_e.data);
                end
            end
            if (!bus.done) lowcnt = lowcnt + 1;
            if (bus.done && !prev_done) begin
                if (rq.size() == 0) chk("unexpected_done", 32'(lowcnt), 32'hDEAD);
                else begin
                    r_e = rq.pop_front();
                    chk("found",      32'(bus.found), 32'(r_e.found));
                    chk("best_nonce", bus.best_nonce, r_e.nonce);
                    chk("best_hash",  bus.best_hash,  r_e.hash);
                    chk("hit_count",  32'(bus.hit_count), 32'(r_e.hits));
                    chk("busy_cycles", 32'(lowcnt), 32'(r_e.lat));
                end
                lowcnt = 0;
            end
            prev_done = bus.done;
            if (sq.size() != 0) begin
                s_e = sq.pop_front();
                chk("snap_done",  32'(bus.done),  32'(s_e.done));
                chk("snap_we",    32'(bus.mem_we), 32'(s_e.we));
                chk("snap_addr",  32'(bus.mem_addr), 32'(s_e.addr));
                chk("snap_wd",    bus.mem_write_data, s_e.wd);
                chk("snap_found", 32'(bus.found), 32'(s_e.found));
                chk("snap_nonce", bus.best_nonce, s_e.nonce);
                chk("snap_hash",  bus.best_hash,  s_e.hash);
                chk("snap_hits",  32'(bus.hit_count), 32'(s_e.hits));
            end
            if (fin_req) begin
                chk("writes_left",  32'(wq.size()), 32'd0);
                chk("results_left", 32'(rq.size()), 32'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    task automatic load(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    task automatic push_idle(input logic f, input logic [31:0] n, input logic [31:0] h,
                             input logic [CNT_W-1:0] c);
        snap_t s;
        s.done = 1'b1; s.we = 1'b0; s.addr = '0; s.wd = '0;
        s.found = f; s.nonce = n; s.hash = h; s.hits = c;
        sq.push_back(s);
    endtask

    task automatic push_scan(input logic [15:0] sa, input logic [31:0] n,
                             input logic [31:0] h, input logic [CNT_W-1:0] c);
        res_t r;
        wq.push_back('{addr: sa,          data: n});
        wq.push_back('{addr: sa + 16'd1,  data: h});
        wq.push_back('{addr: sa + 16'd2,  data: 32'(c)});
        r.found = (c != 0); r.nonce = n; r.hash = h; r.hits = c; r.lat = NUM + 4;
        rq.push_back(r);
    endtask

    task automatic pulse_start(input logic [15:0] ra, input logic [15:0] sa,
                               input logic [31:0] tg);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.result_addr  = ra;
        bus.summary_addr = sa;
        bus.target       = tg;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_scan(input logic [15:0] ra, input logic [15:0] sa, input logic [31:0] tg,
                            input logic [31:0] n, input logic [31:0] h,
                            input logic [CNT_W-1:0] c);
        push_scan(sa, n, h, c);
        pulse_start(ra, sa, tg);
        wait_done();
        push_idle(c != 0, n, h, c);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.result_addr  = '0;
        bus.summary_addr = '0;
        bus.target       = '0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;
        push_idle(1'b0, 32'd0, 32'hFFFF_FFFF, '0);

        // Descending hashes: minimum is the last nonce.
        for (int k = 0; k < NUM; k++) load(16'h0100 + 16'(k), 32'(100 - k));
        run_scan(16'h0100, 16'h0200, 32'd90, 32'd15, 32'd85, 5'd6);

        // All equal, none under target: tie resolves to nonce 0.
        for (int k = 0; k < NUM; k++) load(16'h0300 + 16'(k), 32'h0000_1000);
        run_scan(16'h0300, 16'h0400, 32'd0, 32'd0, 32'h0000_1000, 5'd0);

        for (int k = 0; k < NUM; k++)
            load(16'h0500 + 16'(k), (k == 7) ? 32'd0 : 32'hFFFF_FFFF);
        run_scan(16'h0500, 16'h0600, 32'hFFFF_FFFF, 32'd7, 32'd0, 5'd16);

        // Result and summary ranges wrap past FFFF.
        for (int k = 0; k < NUM; k++)
            load(16'hFFF8 + 16'(k), 32'(300 - ((k * 5) % 16)));
        run_scan(16'hFFF8, 16'hFFFE, 32'd290, 32'd3, 32'd285, 5'd6);

        // Reset in READ cycle 5 aborts with no summary writes.
        begin
            res_t r;
            r.found = 1'b0; r.nonce = 0; r.hash = 32'hFFFF_FFFF; r.hits = '0; r.lat = 6;
            rq.push_back(r);
        end
        pulse_start(16'h0100, 16'h0200, 32'd90);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_idle(1'b0, 32'd0, 32'hFFFF_FFFF, '0);
        repeat (2) @(posedge clk);
        run_scan(16'h0100, 16'h0200, 32'd90, 32'd15, 32'd85, 5'd6);

        // Start pulsed during WRITE must be ignored; target equal to every hash counts all.
        push_scan(16'h0700, 32'd0, 32'h0000_1000, 5'd16);
        pulse_start(16'h0300, 16'h0700, 32'h0000_1000);
        repeat (NUM + 1) @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        push_idle(1'b1, 32'd0, 32'h0000_1000, 5'd16);

        repeat (3) @(posedge clk);
        #1;
        fin_req = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
